// File: rtl/hilo_unit_pkg.sv
// ============================================================================
// Module : hilo_unit_pkg
// Brief  : Shared HI/LO operation field bit indices and FSM state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hilo_unit_pkg;

    localparam int HILO_OP_W     = 13;
    localparam int HILO_OP_MTHI  = 0;
    localparam int HILO_OP_MTLO  = 1;
    localparam int HILO_OP_MFHI  = 2;
    localparam int HILO_OP_MFLO  = 3;
    localparam int HILO_OP_DIV   = 4;
    localparam int HILO_OP_DIVU  = 5;
    localparam int HILO_OP_MULT  = 6;
    localparam int HILO_OP_MULTU = 7;
    localparam int HILO_OP_MUL   = 8;
    localparam int HILO_OP_MADD  = 9;
    localparam int HILO_OP_MADDU = 10;
    localparam int HILO_OP_MSUB  = 11;
    localparam int HILO_OP_MSUBU = 12;

    typedef logic [2:0] hilo_state_t;

    localparam hilo_state_t ST_IDLE     = 3'd0;
    localparam hilo_state_t ST_MUL      = 3'd1;
    localparam hilo_state_t ST_DIV_INIT = 3'd2;
    localparam hilo_state_t ST_DIV_ITER = 3'd3;
    localparam hilo_state_t ST_DIV_FIX  = 3'd4;

    localparam int DIV_ITERS = 32;

endpackage

`default_nettype wire

// File: rtl/hilo_unit_div_radix2.sv
// ============================================================================
// Module : hilo_unit_div_radix2
// Brief  : Radix-2 restoring divider (signed/unsigned) with sign fix-up.
//          Optional early out on small dividend / zero divisor: HILO_DIV_EARLY_OUT_EN
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_unit_div_radix2
    import hilo_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        cancel_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        skip_o,
    output logic        last_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_INIT = 2'd1;
    localparam logic [1:0] PH_ITER = 2'd2;
    localparam logic [1:0] PH_FIX  = 2'd3;

    logic [1:0]  phase_q;
    logic [31:0] raw_a_q, raw_b_q, rem_q, quo_q, dvs_q;
    logic [4:0]  cnt_q;
    logic        sgn_q, qneg_q, rneg_q, zero_q;

    logic [31:0] w_a_mag, w_b_mag;
    logic [32:0] w_shift, w_diff;
    logic        w_fits, w_skip;

    assign w_a_mag = (sgn_q && raw_a_q[31]) ? -raw_a_q : raw_a_q;
    assign w_b_mag = (sgn_q && raw_b_q[31]) ? -raw_b_q : raw_b_q;
    assign w_shift = {rem_q, quo_q[31]};
    assign w_diff  = w_shift - {1'b0, dvs_q};
    assign w_fits  = ~w_diff[32];

`ifdef HILO_DIV_EARLY_OUT_EN
    assign w_skip = (phase_q == PH_INIT) && ((w_b_mag == 32'd0) || (w_a_mag < w_b_mag));
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= PH_IDLE;
            raw_a_q <= '0;
            raw_b_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else if (cancel_i) begin
            phase_q <= PH_IDLE;
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    if (start_i) begin
                        raw_a_q <= dividend_i;
                        raw_b_q <= divisor_i;
                        sgn_q   <= signed_i;
                        phase_q <= PH_INIT;
                    end
                end
                PH_INIT: begin
                    qneg_q <= sgn_q & (raw_a_q[31] ^ raw_b_q[31]);
                    rneg_q <= sgn_q & raw_a_q[31];
                    zero_q <= (raw_b_q == 32'd0);
                    dvs_q  <= w_b_mag;
                    cnt_q  <= 5'(DIV_ITERS - 1);
                    if (w_skip) begin
                        quo_q   <= '0;
                        rem_q   <= w_a_mag;
                        phase_q <= PH_FIX;
                    end else begin
                        quo_q   <= w_a_mag;
                        rem_q   <= '0;
                        phase_q <= PH_ITER;
                    end
                end
                PH_ITER: begin
                    // Dividend bits shift out of quo_q as quotient bits shift in.
                    quo_q <= {quo_q[30:0], w_fits};
                    rem_q <= w_fits ? w_diff[31:0] : w_shift[31:0];
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        phase_q <= PH_FIX;
                    end
                end
                default: phase_q <= PH_IDLE;
            endcase
        end
    end

    assign skip_o = w_skip;
    assign last_o = (phase_q == PH_ITER) && (cnt_q == 5'd0);
    assign done_o = (phase_q == PH_FIX);

    // Divide by zero returns all-ones quotient and the raw dividend as remainder.
    assign quotient_o  = zero_q ? 32'hFFFF_FFFF : (qneg_q ? -quo_q : quo_q);
    assign remainder_o = zero_q ? raw_a_q       : (rneg_q ? -rem_q : rem_q);

endmodule

`default_nettype wire

// File: rtl/hilo_unit.sv
// ============================================================================
// Module : hilo_unit
// Brief  : HI/LO register owner: moves, multiply/MAC and iterative divide.
//          Optional divider early out: HILO_DIV_EARLY_OUT_EN
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int          MUL_LAT    = 2,
    parameter logic [31:0] HILO_RESET = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [HILO_OP_W-1:0] req_op,
    input  logic [31:0]          src1,
    input  logic [31:0]          src2,
    input  logic                 flush,
    output logic                 resp_valid,
    output logic [31:0]          resp_data,
    output logic                 busy,
    output logic [31:0]          hi,
    output logic [31:0]          lo
);

    localparam logic [1:0] MK_SET  = 2'd0;
    localparam logic [1:0] MK_ADD  = 2'd1;
    localparam logic [1:0] MK_SUB  = 2'd2;
    localparam logic [1:0] MK_RESP = 2'd3;
    localparam logic [1:0] MCNT_INIT = 2'(MUL_LAT - 1);

    hilo_state_t state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_valid_q, resp_valid_d;
    logic        msgn_q, msgn_d;
    logic [1:0]  mkind_q, mkind_d, mcnt_q, mcnt_d;

    logic        w_onehot, w_accept, w_is_mul, w_is_div;
    logic [63:0] w_ea, w_eb, w_prod, w_hilo;
    logic        w_div_skip, w_div_last, w_div_done;
    logic [31:0] w_div_q, w_div_r;

    assign w_onehot = (req_op != '0) && ((req_op & (req_op - 13'd1)) == '0);
    assign w_accept = req_valid && (state_q == ST_IDLE) && !flush && w_onehot;
    assign w_is_mul = |req_op[HILO_OP_MSUBU:HILO_OP_MULT];
    assign w_is_div = req_op[HILO_OP_DIV] | req_op[HILO_OP_DIVU];

    assign w_ea   = {{32{msgn_q & a_q[31]}}, a_q};
    assign w_eb   = {{32{msgn_q & b_q[31]}}, b_q};
    assign w_prod = w_ea * w_eb;
    assign w_hilo = {hi_q, lo_q};

    hilo_unit_div_radix2 u_div (
        .clk         (clk),
        .reset       (reset),
        .start_i     (w_accept & w_is_div),
        .cancel_i    (flush),
        .signed_i    (req_op[HILO_OP_DIV]),
        .dividend_i  (src1),
        .divisor_i   (src2),
        .skip_o      (w_div_skip),
        .last_o      (w_div_last),
        .done_o      (w_div_done),
        .quotient_o  (w_div_q),
        .remainder_o (w_div_r)
    );

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        a_d          = a_q;
        b_d          = b_q;
        msgn_d       = msgn_q;
        mkind_d      = mkind_q;
        mcnt_d       = mcnt_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (req_op[HILO_OP_MTHI]) hi_d = src1;
                    if (req_op[HILO_OP_MTLO]) lo_d = src1;
                    if (req_op[HILO_OP_MFHI] || req_op[HILO_OP_MFLO]) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = req_op[HILO_OP_MFHI] ? hi_q : lo_q;
                    end
                    if (w_is_mul) begin
                        state_d = ST_MUL;
                        a_d     = src1;
                        b_d     = src2;
                        mcnt_d  = MCNT_INIT;
                        msgn_d  = req_op[HILO_OP_MULT] | req_op[HILO_OP_MUL] |
                                  req_op[HILO_OP_MADD] | req_op[HILO_OP_MSUB];
                        if (req_op[HILO_OP_MADD] || req_op[HILO_OP_MADDU])
                            mkind_d = MK_ADD;
                        else if (req_op[HILO_OP_MSUB] || req_op[HILO_OP_MSUBU])
                            mkind_d = MK_SUB;
                        else if (req_op[HILO_OP_MUL])
                            mkind_d = MK_RESP;
                        else
                            mkind_d = MK_SET;
                    end
                    if (w_is_div) state_d = ST_DIV_INIT;
                end
            end
            ST_MUL: begin
                if (mcnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                    case (mkind_q)
                        MK_SET:  {hi_d, lo_d} = w_prod;
                        MK_ADD:  {hi_d, lo_d} = w_hilo + w_prod;
                        MK_SUB:  {hi_d, lo_d} = w_hilo - w_prod;
                        default: begin
                            resp_valid_d = 1'b1;
                            resp_data_d  = w_prod[31:0];
                        end
                    endcase
                end else begin
                    mcnt_d = mcnt_q - 2'd1;
                end
            end
            ST_DIV_INIT: state_d = w_div_skip ? ST_DIV_FIX : ST_DIV_ITER;
            ST_DIV_ITER: if (w_div_last) state_d = ST_DIV_FIX;
            ST_DIV_FIX: begin
                state_d = ST_IDLE;
                if (w_div_done) begin
                    lo_d = w_div_q;
                    hi_d = w_div_r;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A flush wins over any commit scheduled for this edge.
        if (flush) begin
            state_d      = ST_IDLE;
            hi_d         = hi_q;
            lo_d         = lo_q;
            resp_valid_d = 1'b0;
            resp_data_d  = resp_data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hi_q         <= HILO_RESET;
            lo_q         <= HILO_RESET;
            a_q          <= '0;
            b_q          <= '0;
            msgn_q       <= 1'b0;
            mkind_q      <= MK_SET;
            mcnt_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            a_q          <= a_d;
            b_q          <= b_d;
            msgn_q       <= msgn_d;
            mkind_q      <= mkind_d;
            mcnt_q       <= mcnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign hi         = hi_q;
    assign lo         = lo_q;

endmodule

`default_nettype wire
